// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Op-code encodings, multiply/divide FSM states, the divide-by-zero
// quotient fill value and a helper that classifies iterative ops.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_JR    = 5'd11;
    localparam logic [4:0] OP_NOP   = 5'd12;
    localparam logic [4:0] OP_MULT  = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;
    localparam logic [4:0] OP_MFHI  = 5'd17;
    localparam logic [4:0] OP_MFLO  = 5'd18;
    localparam logic [4:0] OP_SLTU  = 5'd19;
    localparam logic [4:0] OP_XOR   = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide by zero: every quotient bit is this value, remainder = dividend.
    localparam logic DIV0_LO_FILL = 1'b1;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide core, one bit per clock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands (and process the first bit) on this edge
//   signed_op   operands are two's complement (MULT/DIV)
//   is_div      divide instead of multiply
//   a, b        multiplicand/dividend, multiplier/divisor
//   done        the last bit is processed on the coming edge
//   hi, lo      final result, valid in the cycle after done
// Works on magnitudes; signs are applied to the final registers combinationally.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   acc_q, acc_d;     // partial product high half / remainder
    logic [WIDTH-1:0] x_q, x_d;         // multiplier / quotient shift register
    logic [WIDTH-1:0] m_q, m_d;         // |b|
    logic [WIDTH-1:0] dvd_q, dvd_d;     // original dividend for divide by zero
    logic             div_q, div_d;
    logic             neg_q, neg_d;     // negate product / quotient
    logic             rneg_q, rneg_d;   // negate remainder (dividend was negative)
    logic             div0_q, div0_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   st_acc;
    logic [WIDTH-1:0] st_x, st_m;
    logic             st_div;
    logic [WIDTH:0]   add_sum, mul_sum, shifted, trial;
    logic [WIDTH:0]   nxt_acc;
    logic [WIDTH-1:0] nxt_x;

    // One iteration step. On the start edge it runs on the freshly presented
    // operands so the first bit costs no extra cycle.
    always_comb begin
        a_neg   = signed_op & a[WIDTH-1];
        b_neg   = signed_op & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        st_acc  = start ? '0 : acc_q;
        st_x    = start ? a_mag : x_q;
        st_m    = start ? b_mag : m_q;
        st_div  = start ? is_div : div_q;
        add_sum = st_acc + {1'b0, st_m};
        mul_sum = st_x[0] ? add_sum : st_acc;
        shifted = {st_acc[WIDTH-1:0], st_x[WIDTH-1]};
        trial   = shifted - {1'b0, st_m};
        nxt_acc = '0;
        nxt_x   = '0;
        if (st_div) begin
            // Restoring divide: keep the trial remainder only if it did not borrow.
            if (!trial[WIDTH]) begin
                nxt_acc = trial;
                nxt_x   = {st_x[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = shifted;
                nxt_x   = {st_x[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: {acc,x} shifts right, product grows into acc.
            nxt_acc = {1'b0, mul_sum[WIDTH:1]};
            nxt_x   = {mul_sum[0], st_x[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        acc_d  = acc_q;
        x_d    = x_q;
        m_d    = m_q;
        dvd_d  = dvd_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        div0_d = div0_q;
        if (start) begin
            // WIDTH bits in total: one now, WIDTH-1 more while busy.
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
            acc_d  = nxt_acc;
            x_d    = nxt_x;
            m_d    = b_mag;
            dvd_d  = a;
            div_d  = is_div;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            div0_d = (b == '0);
        end else if (busy_q) begin
            acc_d = nxt_acc;
            x_d   = nxt_x;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            acc_q  <= '0;
            x_q    <= '0;
            m_q    <= '0;
            dvd_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            acc_q  <= acc_d;
            x_q    <= x_d;
            m_q    <= m_d;
            dvd_q  <= dvd_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            div0_q <= div0_d;
        end
    end

    assign done = busy_q && (cnt_q == CW'(1));

    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        prod     = {acc_q[WIDTH-1:0], x_q};
        prod_fix = neg_q ? -prod : prod;
        hi       = prod_fix[2*WIDTH-1:WIDTH];
        lo       = prod_fix[WIDTH-1:0];
        if (div_q) begin
            if (div0_q) begin
                lo = {WIDTH{DIV0_LO_FILL}};
                hi = dvd_q;
            end else begin
                // Truncating division: quotient sign from both, remainder from dividend.
                lo = neg_q ? -x_q : x_q;
                hi = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the execute stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (op_code, reg1, reg2, shamt)
//   out_valid/out_ready   result handshake (result, ovf)
//   dbg_state             current FSM state (alu_pkg::state_e encoding)
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is combinational and never depends on in_valid; out_valid, result
// and ovf stay stable while out_valid && !out_ready.
// Single-cycle ops register their result one edge after accept. MULT/MULTU/
// DIV/DIVU run in alu_muldiv and commit HI/LO plus the result WIDTH+1 edges
// after accept.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op_code,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf;

    assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath.
    always_comb begin
        sum     = reg1 + reg2;
        diff    = reg1 - reg2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = reg1 & reg2;
            OP_OR:   alu_res = reg1 | reg2;
            OP_NOR:  alu_res = ~(reg1 | reg2);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(reg1) < $signed(reg2)};
            OP_SLL:  alu_res = reg1 << shamt;
            OP_SRL:  alu_res = reg1 >> shamt;
            OP_SRA:  alu_res = $signed(reg1) >>> shamt;
            OP_JR:   alu_res = reg1;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, reg1 < reg2};
            OP_XOR:  alu_res = reg1 ^ reg2;
            default: alu_res = '0;
        endcase
    end

    // FSM next state plus output/HI/LO register updates.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_muldiv(op_code)) begin
                        md_start    = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = ST_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        ovf_d       = alu_ovf;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d        = md_hi;
                lo_d        = md_lo;
                result_d    = md_lo;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .signed_op ((op_code == OP_MULT) || (op_code == OP_DIV)),
        .is_div    ((op_code == OP_DIV) || (op_code == OP_DIVU)),
        .a         (reg1),
        .b         (reg2),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op_code;
  logic [W-1:0] reg1;
  logic [W-1:0] reg2;
  logic [4:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic [1:0]   dbg_state;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .reg1      (reg1),
    .reg2      (reg2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           md_acc = -1000;
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: what the ALU must return, straight from the op definitions.
  function automatic logic [W:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [4:0] sh,
                                       inout logic [W-1:0] hi, inout logic [W-1:0] lo);
    logic [W-1:0] r;
    logic         o;
    logic [63:0]  p;
    longint       sa, sb;
    int           ia, ib;
    r = '0;
    o = 1'b0;
    case (op)
      5'd0: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      5'd1: r = a + b;
      5'd2: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      5'd3: r = a - b;
      5'd4: r = a & b;
      5'd5: r = a | b;
      5'd6: r = ~(a | b);
      5'd7: r = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd8: r = a << sh;
      5'd9: r = a >> sh;
      5'd10: r = $signed(a) >>> sh;
      5'd11: r = a;
      5'd13: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        hi = p[63:32]; lo = p[31:0]; r = lo;
      end
      5'd14: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32]; lo = p[31:0]; r = lo;
      end
      5'd15: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
        else begin ia = $signed(a); ib = $signed(b); lo = ia / ib; hi = ia % ib; end
        r = lo;
      end
      5'd16: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
        r = lo;
      end
      5'd17: r = hi;
      5'd18: r = lo;
      5'd19: r = (a < b) ? 1 : 0;
      5'd20: r = a ^ b;
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that took the op.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh, output int waits);
    logic [W:0] mr;
    bit         timed_out;
    in_valid = 1'b1; op_code = op; reg1 = a; reg2 = b; shamt = sh;
    waits = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 64'(waits), 64'd0);
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!timed_out) begin
      mr = model(op, a, b, sh, m_hi, m_lo);
      exp_q.push_back(mr[W-1:0]);
      exp_ovf_q.push_back(mr[W]);
      if (op >= 5'd13 && op <= 5'd16) begin
        exp_cyc_q.push_back(cyc + W + 1);
        md_acc = cyc;
      end else begin
        exp_cyc_q.push_back(cyc + 1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_code = 5'($urandom); reg1 = $urandom; reg2 = $urandom; shamt = 5'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- compare process ----------------
  logic         prev_v = 1'b0;
  logic         prev_hs = 1'b0;
  logic [W-1:0] prev_res;
  logic         prev_ovf;
  int           start_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (cyc > md_acc && cyc <= md_acc + W) check("busy_in_ready", 64'(in_ready), 64'd0);
      if (prev_v && !prev_hs) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", 64'(result), 64'(prev_res));
        check("hold_ovf", 64'(ovf), 64'(prev_ovf));
      end
      if (out_valid && (!prev_v || prev_hs)) start_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          check("result", 64'(result), 64'(exp_q.pop_front()));
          check("ovf", 64'(ovf), 64'(exp_ovf_q.pop_front()));
          check("latency", 64'(start_cyc), 64'(exp_cyc_q.pop_front()));
        end
      end
      prev_v = out_valid;
      prev_hs = out_valid && out_ready;
      prev_res = result;
      prev_ovf = ovf;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] th, tl;
    logic [W-1:0] a, b;
    int w;

    in_valid = 1'b0; op_code = '0; reg1 = '0; reg2 = '0; shamt = '0;
    out_ready = 1'b1; rst_n = 1'b0;

    // Pin the model against hand-computed values.
    th = '0; tl = '0;
    check("pin_add", 64'(model(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, th, tl)), 64'h1_8000_0000);
    check("pin_addu", 64'(model(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, th, tl)), 64'h0_8000_0000);
    check("pin_sra", 64'(model(OP_SRA, 32'hF000_0000, 32'h0, 5'd4, th, tl)), 64'h0_FF00_0000);
    check("pin_srl", 64'(model(OP_SRL, 32'hF000_0000, 32'h0, 5'd4, th, tl)), 64'h0_0F00_0000);
    check("pin_slt", 64'(model(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, th, tl)), 64'h1);
    check("pin_sltu", 64'(model(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, th, tl)), 64'h0);
    void'(model(OP_MULT, 32'hFFFF_FFFD, 32'h5, 5'd0, th, tl));
    check("pin_mult", {32'(th), 32'(tl)}, 64'hFFFF_FFFF_FFFF_FFF1);
    void'(model(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, th, tl));
    check("pin_div", {32'(th), 32'(tl)}, 64'hFFFF_FFFF_FFFF_FFFD);
    void'(model(OP_DIVU, 32'h7, 32'h0, 5'd0, th, tl));
    check("pin_div0", {32'(th), 32'(tl)}, 64'h0000_0007_FFFF_FFFF);
    void'(model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, th, tl));
    check("pin_divmin", {32'(th), 32'(tl)}, 64'h0000_0000_8000_0000);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle and multi-cycle ops.
    send(OP_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, w);
    send(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
    send(OP_SUB,  32'h8000_0000, 32'h1, 5'd0, w);
    send(OP_SRA,  32'hF000_0000, 32'h0, 5'd4, w);
    send(OP_SRL,  32'hF000_0000, 32'h0, 5'd4, w);
    send(OP_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, w);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, w);
    send(OP_NOR,  32'h0F0F_0000, 32'h00F0_00FF, 5'd0, w);
    send(OP_MULT, 32'hFFFF_FFFD, 32'h5, 5'd0, w);
    send(OP_MFHI, 32'h0, 32'h0, 5'd0, w);
    send(OP_MFLO, 32'h0, 32'h0, 5'd0, w);
    send(OP_DIV,  32'hFFFF_FFF9, 32'h2, 5'd0, w);
    send(OP_MFHI, 32'h0, 32'h0, 5'd0, w);
    send(OP_DIVU, 32'h7, 32'h0, 5'd0, w);
    send(OP_MFHI, 32'h0, 32'h0, 5'd0, w);
    send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, w);
    send(OP_MFHI, 32'h0, 32'h0, 5'd0, w);
    send(OP_MFLO, 32'h0, 32'h0, 5'd0, w);
    send(5'd25,   32'h1234_5678, 32'h1, 5'd3, w);
    drain();

    // Back-pressure: AND result held for 5 cycles, then released.
    out_ready = 1'b0;
    send(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, w);
    repeat (5) begin
      @(negedge clk);
      check("hold_and_valid", 64'(out_valid), 64'd1);
      check("hold_and_result", 64'(result), 64'h0F00_0F00);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_OR, 32'hA, 32'h5, 5'd0, w);
    check("release_accept_wait", 64'(w), 64'd0);
    drain();

    // Reset in the middle of a divide.
    send(OP_DIV, 32'd100, 32'd7, 5'd0, w);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.delete(); exp_ovf_q.delete(); exp_cyc_q.delete();
    m_hi = '0; m_lo = '0; md_acc = -1000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(OP_MFHI, 32'h0, 32'h0, 5'd0, w);
    send(OP_MFLO, 32'h0, 32'h0, 5'd0, w);
    send(OP_ADD, 32'd5, 32'd6, 5'd0, w);
    drain();

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    repeat (300) begin
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
      send(5'($urandom_range(0, 31)), a, b, 5'($urandom), w);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 64'd1, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
